// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and width helpers for the SPI transfer scheduler
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 32;
    localparam int SPI_NUM_SLAVES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CAPTURE
    } sched_state_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // TX FIFO entry; its field widths pin DATA_WIDTH/NUM_SLAVES to the package values.
    typedef struct packed {
        logic [SPI_DATA_WIDTH-1:0]          data;
        logic [$clog2(SPI_NUM_SLAVES)-1:0]  slave;
    } tx_entry_t;

endpackage

// File: rtl/spi_xfer_scheduler_if.sv
// rtl/spi_xfer_scheduler_if.sv - host and SPI-master side signals of the transfer scheduler
interface spi_xfer_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int FIFO_DEPTH = 16
);
    import spi_pkg::*;

    logic                          wr_valid;
    logic                          wr_ready;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [$clog2(NUM_SLAVES)-1:0] wr_slave;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          m_start_tx;
    logic [DATA_WIDTH-1:0]         m_tx_data;
    logic [NUM_SLAVES-1:0]         m_slave_sel;
    logic                          m_busy;
    logic                          m_irq;
    logic [DATA_WIDTH-1:0]         m_rx_data;
    logic [lvl_w(FIFO_DEPTH)-1:0]  tx_level;
    logic [lvl_w(FIFO_DEPTH)-1:0]  rx_level;
    logic                          xfer_done;
    logic                          timeout_err;

    modport slave (
        input  wr_valid, wr_data, wr_slave, rd_ready, m_busy, m_irq, m_rx_data,
        output wr_ready, rd_valid, rd_data, m_start_tx, m_tx_data, m_slave_sel,
               tx_level, rx_level, xfer_done, timeout_err
    );

    modport master (
        output wr_valid, wr_data, wr_slave, rd_ready, m_busy, m_irq, m_rx_data,
        input  wr_ready, rd_valid, rd_data, m_start_tx, m_tx_data, m_slave_sel,
               tx_level, rx_level, xfer_done, timeout_err
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy output
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [lvl_w(DEPTH)-1:0] o_level
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// rtl/spi_xfer_scheduler.sv - buffers host words and launches one SPI master transfer per word
module spi_xfer_scheduler
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int NUM_SLAVES   = SPI_NUM_SLAVES,
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    spi_xfer_scheduler_if.slave bus
);
    localparam int LVL_W = lvl_w(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    sched_state_t          r_state;
    tx_entry_t             r_entry;
    logic [DATA_WIDTH-1:0] r_rx_word;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_start;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [NUM_SLAVES-1:0] r_sel;
    logic                  r_done;
    logic                  r_err;

    tx_entry_t             w_tx_in;
    tx_entry_t             w_tx_head;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic                  w_tx_pop;
    logic [LVL_W-1:0]      w_tx_level;
    logic [DATA_WIDTH-1:0] w_rx_head;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_rx_push;
    logic [LVL_W-1:0]      w_rx_level;

    assign w_tx_in.data  = bus.wr_data;
    assign w_tx_in.slave = bus.wr_slave;

    // Launch only with RX room reserved, so a returned word can never be dropped.
    assign w_tx_pop  = (r_state == ST_IDLE) && !w_tx_empty && !w_rx_full;
    assign w_rx_push = (r_state == ST_CAPTURE);

    spi_sync_fifo #(.WIDTH($bits(tx_entry_t)), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.wr_valid),
        .i_push_data (w_tx_in),
        .i_pop       (w_tx_pop),
        .o_data      (w_tx_head),
        .o_empty     (w_tx_empty),
        .o_full      (w_tx_full),
        .o_level     (w_tx_level)
    );

    spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rx_push),
        .i_push_data (r_rx_word),
        .i_pop       (bus.rd_ready),
        .o_data      (w_rx_head),
        .o_empty     (w_rx_empty),
        .o_full      (w_rx_full),
        .o_level     (w_rx_level)
    );

    assign bus.wr_ready    = !w_tx_full || w_tx_pop;
    assign bus.rd_valid    = !w_rx_empty;
    assign bus.rd_data     = w_rx_head;
    assign bus.tx_level    = w_tx_level;
    assign bus.rx_level    = w_rx_level;
    assign bus.m_start_tx  = r_start;
    assign bus.m_tx_data   = r_tx_data;
    assign bus.m_slave_sel = r_sel;
    assign bus.xfer_done   = r_done;
    assign bus.timeout_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_entry   <= '0;
            r_rx_word <= '0;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_tx_data <= '0;
            r_sel     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tx_pop) begin
                        r_entry <= w_tx_head;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_tx_data <= r_entry.data;
                    r_sel     <= NUM_SLAVES'(1) << r_entry.slave;
                    r_start   <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // A completion seen before busy still counts as a finished transfer.
                    if (bus.m_irq) begin
                        r_rx_word <= bus.m_rx_data;
                        r_state   <= ST_CAPTURE;
                    end else if (bus.m_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.m_irq) begin
                        r_rx_word <= bus.m_rx_data;
                        r_state   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_done  <= 1'b1;
                    r_sel   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
